// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS-subset control sequencer:
// opcode values, ALU operation codes, FSM state codes and the opcode class record.
package mc_control_fsm_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    // aluop encoding understood by the existing ALU control block
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;

    // FSM state codes, visible on the debug state output
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    // One-hot instruction class; is_bad marks any opcode outside the subset
    typedef struct packed {
        logic is_r;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_imm;
        logic is_j;
        logic is_bad;
    } op_class_t;

endpackage

// File: rtl/mc_op_class.sv
// Opcode classifier: maps the 6-bit opcode onto an instruction class and,
// for the immediate ALU group, the ALU operation the EXEC step needs.
module mc_op_class
    import mc_control_fsm_pkg::*;
(
    input  logic [5:0] opcode_i,
    output op_class_t  cls_o,
    output logic [2:0] imm_aluop_o
);

    // Pure decode; unknown opcodes land on is_bad so the sequencer can trap
    always_comb begin
        cls_o       = '0;
        imm_aluop_o = ALU_ADD;
        case (opcode_i)
            OP_RTYPE: cls_o.is_r   = 1'b1;
            OP_LW:    cls_o.is_lw  = 1'b1;
            OP_SW:    cls_o.is_sw  = 1'b1;
            OP_BEQ:   cls_o.is_beq = 1'b1;
            OP_J:     cls_o.is_j   = 1'b1;
            OP_ADDI: begin
                cls_o.is_imm = 1'b1;
                imm_aluop_o  = ALU_ADD;
            end
            OP_ANDI: begin
                cls_o.is_imm = 1'b1;
                imm_aluop_o  = ALU_AND;
            end
            OP_ORI: begin
                cls_o.is_imm = 1'b1;
                imm_aluop_o  = ALU_OR;
            end
            OP_SLTI: begin
                cls_o.is_imm = 1'b1;
                imm_aluop_o  = ALU_SLT;
            end
            default:  cls_o.is_bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer for the MIPS-subset datapath.
// Steps FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data memory,
// counts retired instructions and traps on illegal opcodes or memory timeouts.
//
// Memory handshake: a request (imem_req, or er/ew for data) is held high for
// the whole time the FSM sits in the requesting state. The cycle in which the
// matching ack is sampled high completes the transfer; the FSM leaves the state
// on that edge so the request drops the next cycle. An ack in the first cycle
// of the request is legal. Acks seen in any other state are ignored.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             regdst,
    output logic             regwrite,
    output logic             memtoreg,
    output logic             alusrc,
    output logic             er,
    output logic             ew,
    output logic             PCSrc,
    output logic             jump,
    output logic [2:0]       aluop,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    logic [2:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic             retire;
    logic             timeout_hit;
    op_class_t        cls;
    logic [2:0]       imm_aluop;

    mc_op_class u_op_class (
        .opcode_i    (opcode),
        .cls_o       (cls),
        .imm_aluop_o (imm_aluop)
    );

    // This cycle would be the TIMEOUT-th one spent waiting; an ack in it still wins
    assign timeout_hit = (({1'b0, wait_q} + 9'd1) == 9'(TIMEOUT));

    // Next-state, retire strobe and sticky flag updates
    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (cls.is_j) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (cls.is_bad) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls.is_beq) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (cls.is_lw || cls.is_sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (cls.is_sw) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase
    end

    // Wait counter runs only while a request state is held; any state change clears it
    always_comb begin
        wait_d = 8'd0;
        if ((state_d == state_q) && ((state_q == ST_FETCH) || (state_q == ST_MEM))) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State, counters and sticky flags; synchronous reset drops any request in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            wait_q    <= 8'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Control outputs decoded from state and opcode; every unused field drives 0
    always_comb begin
        imem_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        regdst   = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        alusrc   = 1'b0;
        er       = 1'b0;
        ew       = 1'b0;
        PCSrc    = 1'b0;
        jump     = 1'b0;
        aluop    = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ack;
                pc_write = imem_ack;
            end
            ST_DECODE: begin
                if (cls.is_j) begin
                    jump     = 1'b1;
                    pc_write = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cls.is_r) begin
                    aluop = ALU_FUNCT;
                end else if (cls.is_lw || cls.is_sw) begin
                    alusrc = 1'b1;
                    aluop  = ALU_ADD;
                end else if (cls.is_imm) begin
                    alusrc = 1'b1;
                    aluop  = imm_aluop;
                end else if (cls.is_beq) begin
                    aluop    = ALU_SUB;
                    PCSrc    = 1'b1;
                    pc_write = zero;
                end
            end
            ST_MEM: begin
                if (cls.is_lw) begin
                    er     = 1'b1;
                    alusrc = 1'b1;
                end else if (cls.is_sw) begin
                    ew     = 1'b1;
                    alusrc = 1'b1;
                end
            end
            ST_WB: begin
                regwrite = 1'b1;
                regdst   = cls.is_r;
                memtoreg = cls.is_lw;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign retired = retired_q;

endmodule
